// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops 16-bit words from the async FIFO read side
// and packs word pairs into 32-bit beats, flushing a lone tail word.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    rd_clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  input  logic                    fifo_valid,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic                    rd_en,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic [1:0]              m_keep
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] DEPTH = PW'(BUF_DEPTH);
  localparam logic [IW-1:0] TMO   = IW'(TIMEOUT);

  typedef enum logic {COLLECT, TAIL} state_t;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0] wptr, rptr, count, rstep;
  logic [PW:0]   occ;
  logic [AW-1:0] ridx0, ridx1;
  logic          inflight;
  logic          push, out_free;
  logic          load_full, load_half;
  logic          tail_cond;
  state_t        state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;

  assign count = wptr - rptr;
  assign occ   = {1'b0, count} + {{PW{1'b0}}, inflight};
  assign rd_en = rst_n & ~fifo_empty & (occ < {1'b0, DEPTH});

  // A valid word with no room is dropped rather than overwrite live data
  assign push  = fifo_valid & (count != DEPTH);
  assign ridx0 = rptr[AW-1:0];
  assign ridx1 = rptr[AW-1:0] + AW'(1);

  assign out_free  = ~m_valid | m_ready;
  assign load_full = out_free & (count >= PW'(2));
  assign load_half = out_free & ~load_full &
                     (state == TAIL) & (idle_cnt == TMO);

  assign tail_cond = (count == PW'(1)) & ~inflight & fifo_empty;

  always_comb begin
    rstep = '0;
    unique case (1'b1)
      load_full: rstep = PW'(2);
      load_half: rstep = PW'(1);
      default:   rstep = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    unique case (state)
      COLLECT: begin
        if (tail_cond) begin
          state_nxt = TAIL;
          idle_nxt  = '0;
        end
      end
      TAIL: begin
        if (!tail_cond || load_half) begin
          state_nxt = COLLECT;
          idle_nxt  = '0;
        end else if (idle_cnt != TMO) begin
          idle_nxt = idle_cnt + IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (push) mem[wptr[AW-1:0]] <= fifo_dout;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      state    <= COLLECT;
      idle_cnt <= '0;
    end else begin
      wptr     <= wptr + PW'(push);
      rptr     <= rptr + rstep;
      inflight <= rd_en;
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= 2'b00;
    end else if (load_full) begin
      m_valid <= 1'b1;
      m_data  <= {mem[ridx1], mem[ridx0]};
      m_keep  <= 2'b11;
    end else if (load_half) begin
      m_valid <= 1'b1;
      m_data  <= {{DATA_WIDTH{1'b0}}, mem[ridx0]};
      m_keep  <= 2'b01;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed bench for fifo_rd_packer with a
// behavioural one-cycle-latency FIFO model.
module tb_fifo_rd_packer;

  logic        rd_clk;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_valid;
  logic [15:0] fifo_dout;
  logic        rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [1:0]  m_keep;

  fifo_rd_packer #(
    .DATA_WIDTH(16),
    .BUF_DEPTH (4),
    .TIMEOUT   (16)
  ) dut (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid),
    .fifo_dout (fifo_dout),
    .rd_en     (rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q [$];
  logic [31:0] bd [$];
  logic [1:0]  bk [$];
  int          bt [$];
  int          cyc = 0;
  int          rd_cnt, first_rd, last_rd, first_mv;
  logic        s_rd, s_mv;
  logic [31:0] s_md;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    rd_cnt   = 0;
    first_rd = -1;
    last_rd  = -1;
    first_mv = -1;
    bd.delete();
    bk.delete();
    bt.delete();
  endtask

  task automatic load(input logic [15:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Sample at negedge; update the FIFO model just after posedge
  task automatic tick;
    @(negedge rd_clk);
    cyc++;
    s_rd = rd_en;
    s_mv = m_valid;
    s_md = m_data;
    if (rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (m_valid && m_ready) begin
      bd.push_back(m_data);
      bk.push_back(m_keep);
      bt.push_back(cyc);
    end
    @(posedge rd_clk);
    #1;
    if (s_rd && q.size() > 0) begin
      fifo_dout  = q.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_valid = 1'b0;
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic wait_beats(input int n, input int bound);
    int t;
    t = 0;
    while (bd.size() < n && t < bound) begin
      tick();
      t++;
    end
    chk("beat_timeout", 32'(bd.size() >= n), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    fifo_empty = 1'b0;
    fifo_valid = 1'b0;
    fifo_dout  = '0;
    m_ready    = 1'b1;
    clr();
    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_m_keep", 32'(m_keep), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    fifo_empty = 1'b1;
    @(posedge rd_clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();

    // Two words -> one full beat, latency from accepting edge
    clr();
    load(16'h0001);
    load(16'h0002);
    wait_beats(1, 20);
    chk("t1_data", bd[0], 32'h0002_0001);
    chk("t1_keep", 32'(bk[0]), 32'd3);
    chk("t1_latency", 32'(first_mv - first_rd), 32'd4);
    repeat (4) tick();

    // Streaming 16 words, m_ready high
    clr();
    for (int i = 0; i < 16; i++) load(16'h0100 + 16'(i));
    wait_beats(8, 60);
    repeat (4) tick();
    chk("t2_rd_cnt", 32'(rd_cnt), 32'd16);
    chk("t2_rd_span", 32'(last_rd - first_rd), 32'd15);
    chk("t2_beat_span", 32'(bt[7] - bt[0]), 32'd14);
    for (int i = 0; i < 8; i++)
      chk("t2_data", bd[i],
          {16'h0100 + 16'(2*i+1), 16'h0100 + 16'(2*i)});

    // Backpressure: 20 stalled cycles
    clr();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) load(16'h0100 + 16'(i));
    repeat (20) tick();
    chk("t3_rd_cnt_stall", 32'(rd_cnt), 32'd6);
    chk("t3_mv_stall", 32'(s_mv), 32'd1);
    chk("t3_md_stall", s_md, 32'h0101_0100);
    m_ready = 1'b1;
    wait_beats(8, 80);
    repeat (4) tick();
    chk("t3_rd_cnt", 32'(rd_cnt), 32'd16);
    for (int i = 0; i < 8; i++)
      chk("t3_data", bd[i],
          {16'h0100 + 16'(2*i+1), 16'h0100 + 16'(2*i)});

    // Lone word flushed as a half beat after timeout
    clr();
    load(16'hBEEF);
    wait_beats(1, 40);
    chk("t4_data", bd[0], 32'h0000_BEEF);
    chk("t4_keep", 32'(bk[0]), 32'd1);
    chk("t4_latency", 32'(first_mv - first_rd), 32'd20);
    repeat (3) tick();

    // Second word arrives mid-timeout -> full beat instead
    clr();
    load(16'hBEEF);
    repeat (13) tick();
    chk("t5_no_half", 32'(bd.size()), 32'd0);
    load(16'hCAFE);
    wait_beats(1, 30);
    chk("t5_data", bd[0], 32'hCAFE_BEEF);
    chk("t5_keep", 32'(bk[0]), 32'd3);
    repeat (25) tick();
    chk("t5_no_extra", 32'(bd.size()), 32'd1);

    // Asynchronous reset mid-operation
    clr();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(16'h0011 + 16'(i));
    repeat (12) tick();
    chk("t6_mv_pre", 32'(s_mv), 32'd1);
    #2;
    rst_n      = 1'b0;
    fifo_empty = 1'b0;
    #1;
    chk("t6_rst_mv", 32'(m_valid), 32'd0);
    chk("t6_rst_md", m_data, 32'h0);
    chk("t6_rst_mk", 32'(m_keep), 32'd0);
    chk("t6_rst_rd", 32'(rd_en), 32'd0);
    q.delete();
    fifo_empty = 1'b1;
    fifo_valid = 1'b0;
    @(posedge rd_clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    clr();
    load(16'hAAAA);
    load(16'h5555);
    wait_beats(1, 20);
    chk("t6_data", bd[0], 32'h5555_AAAA);
    chk("t6_keep", 32'(bk[0]), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
